// File: rtl/sap1_loader_pkg.sv
// Shared definitions for the SAP-1 front-panel program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sap1_loader_pkg;

  // Default geometry of the SAP-1 16x8 RAM and the write-strobe width.
  localparam int DEF_ADDR_W       = 4;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_WRITE_CYCLES = 2;

  // Width of the write-pulse down-counter; strobe widths 1..15 fit in 4 bits.
  localparam int TMR_W = 4;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_SETUP  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM programming bus of the program loader.
// Latency: n/a (signal bundle only).
// Backpressure: DATA_READY qualifies DATA_VALID; a byte moves when both are high at a rising edge.
interface program_loader_if
  import sap1_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] DATA_IN;
  logic              DATA_VALID;
  logic              DATA_READY;
  logic [ADDR_W-1:0] PROG_ADDR;
  logic [DATA_W-1:0] PROG_DATA;
  logic              PROG_WE_bar;

  // Byte source side: offers bytes, observes the RAM programming path.
  modport master (
    output DATA_IN, DATA_VALID,
    input  DATA_READY, PROG_ADDR, PROG_DATA, PROG_WE_bar
  );

  // Loader side: accepts bytes and drives the RAM programming path.
  modport slave (
    input  DATA_IN, DATA_VALID,
    output DATA_READY, PROG_ADDR, PROG_DATA, PROG_WE_bar
  );

endinterface

// File: rtl/program_loader_write_pulse_timer.sv
// Loadable down-counter that times the width of the RAM write strobe.
// Latency: expired rises WRITE_CYCLES-1 clocks after the loading edge (same cycle when WRITE_CYCLES=1).
// Backpressure: none; start reloads the counter unconditionally.
module write_pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             CLR_bar,
  input  logic             start,
  input  logic [CNT_W-1:0] WRITE_CYCLES,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Load on start so the first strobe clock already counts; then count down and park at zero.
  always_ff @(posedge CLK) begin
    if (!CLR_bar) begin
      count <= '0;
    end else if (start) begin
      count <= WRITE_CYCLES - CNT_W'(1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // Zero marks the last clock of the strobe.
  assign expired = (count == '0);

endmodule

// File: rtl/program_loader.sv
// SAP-1 program loader: takes bytes over valid/ready and writes them to RAM with timed strobes, then releases the CPU.
// Latency: byte accepted at edge E -> strobe low E+1..E+WRITE_CYCLES -> ready again from edge E+WRITE_CYCLES+2.
// Backpressure: DATA_READY is high only while waiting for a byte; low through setup, strobe, hold and after loading.
module program_loader
  import sap1_loader_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = 2 ** ADDR_W,
  parameter int WRITE_CYCLES = DEF_WRITE_CYCLES
) (
  input  logic              CLK,
  input  logic              CLR_bar,
  input  logic              LOAD_START,
  input  logic              RUN_START,
  input  logic              LOAD_END,
  program_loader_if.slave   bus,
  output logic              CPU_CLR_bar,
  output logic              RUN,
  output logic [ADDR_W:0]   BYTES_LOADED
);

  localparam int                BYTES_W   = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0]  WC_LOAD   = TMR_W'(WRITE_CYCLES);

  state_t              state_q, state_d;
  logic                end_flag_q, end_flag_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_bar_q, we_bar_d;
  logic                clr_bar_q, clr_bar_d;
  logic                run_q, run_d;
  logic [BYTES_W-1:0]  bytes_q, bytes_d;

  logic                timer_start;
  logic                timer_expired;

  // The strobe counter is loaded during SETUP so it is already running on the first WRITE clock.
  assign timer_start = (state_q == ST_SETUP);

  write_pulse_timer #(
    .CNT_W (TMR_W)
  ) u_write_pulse_timer (
    .CLK          (CLK),
    .CLR_bar      (CLR_bar),
    .start        (timer_start),
    .WRITE_CYCLES (WC_LOAD),
    .expired      (timer_expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!CLR_bar) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of every registered output; outputs reflect the state being entered.
  always_comb begin
    state_d    = state_q;
    end_flag_d = end_flag_q;
    ready_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    we_bar_d   = 1'b1;
    clr_bar_d  = clr_bar_q;
    run_d      = run_q;
    bytes_d    = bytes_q;

    case (state_q)
      ST_IDLE: begin
        clr_bar_d = 1'b0;
        run_d     = 1'b0;
        // LOAD_START has priority over RUN_START.
        if (LOAD_START) begin
          state_d = ST_ACCEPT;
          ready_d = 1'b1;
          addr_d  = '0;
          bytes_d = '0;
        end else if (RUN_START) begin
          state_d   = ST_DONE;
          clr_bar_d = 1'b1;
          run_d     = 1'b1;
        end
      end

      ST_ACCEPT: begin
        if (bus.DATA_VALID && ready_q) begin
          // A byte that arrives with LOAD_END is still written, then loading stops.
          state_d    = ST_SETUP;
          data_d     = bus.DATA_IN;
          end_flag_d = LOAD_END;
        end else if (LOAD_END) begin
          state_d   = ST_DONE;
          clr_bar_d = 1'b1;
          run_d     = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end

      ST_SETUP: begin
        state_d  = ST_WRITE;
        we_bar_d = 1'b0;
      end

      ST_WRITE: begin
        if (timer_expired) begin
          state_d = ST_HOLD;
        end else begin
          we_bar_d = 1'b0;
        end
      end

      ST_HOLD: begin
        bytes_d = bytes_q + BYTES_W'(1);
        // The address never wraps: the last location ends the session.
        if (end_flag_q || (addr_q == LAST_ADDR)) begin
          state_d   = ST_DONE;
          clr_bar_d = 1'b1;
          run_d     = 1'b1;
        end else begin
          state_d = ST_ACCEPT;
          ready_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end

      ST_DONE: begin
        // RUN_START is meaningless here; only a new load leaves DONE.
        if (LOAD_START) begin
          state_d   = ST_ACCEPT;
          ready_d   = 1'b1;
          addr_d    = '0;
          bytes_d   = '0;
          clr_bar_d = 1'b0;
          run_d     = 1'b0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clr_bar_d = 1'b0;
        run_d     = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset releases the strobe and holds the CPU in clear.
  always_ff @(posedge CLK) begin
    if (!CLR_bar) begin
      end_flag_q <= 1'b0;
      ready_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      we_bar_q   <= 1'b1;
      clr_bar_q  <= 1'b0;
      run_q      <= 1'b0;
      bytes_q    <= '0;
    end else begin
      end_flag_q <= end_flag_d;
      ready_q    <= ready_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_bar_q   <= we_bar_d;
      clr_bar_q  <= clr_bar_d;
      run_q      <= run_d;
      bytes_q    <= bytes_d;
    end
  end

  assign bus.DATA_READY  = ready_q;
  assign bus.PROG_ADDR   = addr_q;
  assign bus.PROG_DATA   = data_q;
  assign bus.PROG_WE_bar = we_bar_q;
  assign CPU_CLR_bar     = clr_bar_q;
  assign RUN             = run_q;
  assign BYTES_LOADED    = bytes_q;

endmodule
